// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in/serial-out transmitter.
//   state_t        FSM state encoding (ST_IDLE, ST_SHIFT, ST_PARITY)
//   DEFAULT_WIDTH  default data word width
// ST_PARITY is only reachable when PISO_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
// Counts the data bit currently on the serial line, 0..WIDTH-1.
// The counter saturates at WIDTH-1 and never exceeds it.
// Ports:
//   clock   in   posedge clock
//   reset   in   synchronous, active-high; clears the count
//   clear   in   load zero (start of a new word / end of frame)
//   enable  in   advance to the next bit
//   tc      out  terminal count: count == WIDTH-1 (last data bit on the line)
// -----------------------------------------------------------------------------
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == LAST);

endmodule : piso_bit_counter

// File: rtl/piso_tx_8b.sv
// -----------------------------------------------------------------------------
// piso_tx_8b
// Parallel-in/serial-out transmitter. Accepts one word per valid/ready
// handshake and drives it MSB-first on a 1-bit serial line, one bit per
// clock, so a downstream serial-in shift register holds the word after the
// last data bit. Back-to-back words are sent with no gap.
//
// Optional feature (compile-time macro PISO_PARITY_EN):
//   defined   -> one extra even-parity bit (^word) follows the LSB;
//                frame is WIDTH+1 cycles, in_ready reasserts in the parity cycle.
//   undefined -> frame is WIDTH cycles, in_ready reasserts in the last data
//                bit cycle.
//
// Ports:
//   clock      in   posedge clock
//   reset      in   synchronous, active-high; aborts any frame in flight
//   in_data    in   word to transmit, sampled only on accept
//   in_valid   in   producer has a word
//   in_ready   out  block can accept a word this cycle (combinational)
//   ser_out    out  registered serial data, MSB first
//   ser_valid  out  registered; high while ser_out carries a frame bit
//   word_done  out  registered 1-cycle pulse after the last frame bit is sampled
// -----------------------------------------------------------------------------
module piso_tx_8b
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done
);

  state_t           state;
  // Bits still to be sent after the one currently on ser_out.
  logic [WIDTH-2:0] rest;
  logic             last_bit;
  logic             accept;
  logic             frame_end;
`ifdef PISO_PARITY_EN
  logic             parity_bit;
`endif

  // A frame ends in the cycle its final bit is on the line; the counter is
  // cleared there (or on a new accept) so it restarts from zero.
  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept | frame_end),
    .enable ((state == ST_SHIFT) && !last_bit),
    .tc     (last_bit)
  );

  // NOTE: every combinational output gets a value on every path through the
  // block; a missing branch would infer a latch.
  always_comb begin
    in_ready  = 1'b0;
    frame_end = 1'b0;
`ifdef PISO_PARITY_EN
    in_ready  = !reset && ((state == ST_IDLE) || (state == ST_PARITY));
    frame_end = (state == ST_PARITY);
`else
    in_ready  = !reset && ((state == ST_IDLE) ||
                           ((state == ST_SHIFT) && last_bit));
    frame_end = (state == ST_SHIFT) && last_bit;
`endif
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      rest       <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      word_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // Pulses in the cycle after the edge that samples the last frame bit.
      word_done <= frame_end;

      if (accept) begin
        // MSB goes straight onto the line; a back-to-back accept therefore
        // leaves no gap between frames.
        state      <= ST_SHIFT;
        ser_out    <= in_data[WIDTH-1];
        rest       <= in_data[WIDTH-2:0];
        ser_valid  <= 1'b1;
`ifdef PISO_PARITY_EN
        parity_bit <= ^in_data;
`endif
      end else begin
        case (state)
          ST_SHIFT: begin
            if (!last_bit) begin
              ser_out <= rest[WIDTH-2];
              rest    <= {rest[WIDTH-3:0], 1'b0};
            end else begin
`ifdef PISO_PARITY_EN
              state   <= ST_PARITY;
              ser_out <= parity_bit;
`else
              state     <= ST_IDLE;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
`endif
            end
          end
          default: begin
            // ST_IDLE, and the end of the parity cycle with no new word.
            state     <= ST_IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : piso_tx_8b

// File: tb/tb_piso_tx_8b.sv
// -----------------------------------------------------------------------------
// tb_piso_tx_8b
// Self-checking bench for piso_tx_8b. The transmitter feeds an 8-bit
// serial-in shift register (q) that models the downstream stage. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// Build with +define+PISO_PARITY_EN to exercise the parity frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piso_tx_8b;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;   // even parity of data, computed by hand
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       word_done;
  logic [7:0] q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_tx_8b #(.WIDTH(8)) dut (
    .clock     (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .word_done (word_done)
  );

  // Downstream 8-bit serial-in shift register (shift_8b).
  always @(posedge clk) begin
    if (reset) q <= 8'h00;
    else       q <= {q[6:0], ser_out};
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single word from IDLE; checks every frame bit, q and the done pulse.
  task automatic send_byte(input logic [7:0] data, input logic par);
    logic exp_bit;
    in_data  = data;
    in_valid = 1'b1;
    check("idle_ready", in_ready, 1);
    tick();                          // accept edge E
    in_valid = 1'b0;
    in_data  = ~data;                // must be ignored from now on
    for (int k = 0; k < FRAME; k++) begin
      exp_bit = (k < 8) ? data[7-k] : par;
      check("sb_valid", ser_valid, 1);
      check("sb_bit",   ser_out,   exp_bit);
      check("sb_done",  word_done, 0);
      check("sb_ready", in_ready,  (k == FRAME - 1));
      tick();
      if (k == 7) check("sb_q", q, data);
    end
    check("sb_done_pulse", word_done, 1);
    check("sb_end_valid",  ser_valid, 0);
    check("sb_end_out",    ser_out,   0);
    check("sb_end_ready",  in_ready,  1);
    tick();
    check("sb_done_once",  word_done, 0);
  endtask

  // Two words back to back. With garbage=1, in_data is junk while the block
  // is not ready, so an early resample would corrupt the second frame.
  task automatic b2b(input logic [7:0] first, input logic [7:0] second,
                     input logic garbage);
    logic [7:0] w;
    logic       exp_bit;
    int         j;
    in_data  = first;
    in_valid = 1'b1;
    check("b2b_ready0", in_ready, 1);
    tick();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i < FRAME - 1) begin
        in_valid = 1'b1;
        in_data  = garbage ? (8'hE0 ^ 8'(i)) : second;
      end else if (i == FRAME - 1) begin
        in_valid = 1'b1;
        in_data  = second;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h55;
      end
      w = (i < FRAME) ? first : second;
      j = i % FRAME;
      exp_bit = (j < 8) ? w[7-j] : ^w;
      check("b2b_valid", ser_valid, 1);
      check("b2b_bit",   ser_out,   exp_bit);
      check("b2b_ready", in_ready,  (j == FRAME - 1));
      check("b2b_done",  word_done, (i == FRAME));
      tick();
      if (i == 7)         check("b2b_q1", q, first);
      if (i == FRAME + 7) check("b2b_q2", q, second);
    end
    check("b2b_done2",     word_done, 1);
    check("b2b_end_valid", ser_valid, 0);
    tick();
    check("b2b_done_once", word_done, 0);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{data: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h07, par: 1'b1};
    vecs[2] = '{data: 8'hFF, par: 1'b0};
    vecs[3] = '{data: 8'h01, par: 1'b1};
    vecs[4] = '{data: 8'h80, par: 1'b1};
    vecs[5] = '{data: 8'h00, par: 1'b0};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check("rst_valid", ser_valid, 0);
    check("rst_out",   ser_out,   0);
    check("rst_done",  word_done, 0);
    check("rst_ready", in_ready,  0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);

    // Idle with in_valid low.
    for (int i = 0; i < 20; i++) begin
      check("idle_valid", ser_valid, 0);
      check("idle_out",   ser_out,   0);
      check("idle_done",  word_done, 0);
      check("idle_ready", in_ready,  1);
      tick();
    end

    // Single-word table.
    for (int v = 0; v < 6; v++) begin
      send_byte(vecs[v].data, vecs[v].par);
      tick();
    end

    // Back-to-back with in_valid held, then with junk data under backpressure.
    b2b(8'h3C, 8'hC3, 1'b0);
    b2b(8'h5A, 8'h96, 1'b1);

    // Reset while bit 4 of 8'hFF is on the line.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("abort_bit4", ser_out, 1);
    reset = 1'b1;
    tick();
    check("abort_valid", ser_valid, 0);
    check("abort_out",   ser_out,   0);
    check("abort_done",  word_done, 0);
    check("abort_ready", in_ready,  0);
    reset = 1'b0;
    #1;
    check("abort_ready_rel", in_ready, 1);
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      check("abort_no_done", word_done, 0);
    end
    send_byte(8'h01, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_piso_tx_8b
